// File: rtl/i2c_fifo_pkg.sv
// Shared definitions for the i2c_fifo buffers and the APB status register.
// Default geometry matches module_i2c so both sides agree on word and pointer widths.
package i2c_fifo_pkg;

   localparam int I2C_FIFO_DWIDTH = 32;
   localparam int I2C_FIFO_AWIDTH = 4;

   // Number of entries addressed by a pointer of aw bits (wrap bit excluded).
   function automatic int fifo_depth(input int aw);
      return 1 << aw;
   endfunction

   typedef struct packed {
      logic f_full;
      logic f_empty;
      logic f_afull;
      logic err_overflow;
      logic err_underflow;
   } fifo_status_t;

endpackage

// File: rtl/i2c_fifo_mem.sv
// Dual-port register array: synchronous write, asynchronous read.
// Contents are never reset; the FIFO masks the read port while empty.
module i2c_fifo_mem
   import i2c_fifo_pkg::*;
#(
   parameter int DWIDTH = I2C_FIFO_DWIDTH,
   parameter int AWIDTH = I2C_FIFO_AWIDTH
) (
   input  logic              i_clk,
   input  logic              i_wr_en,
   input  logic [AWIDTH-1:0] i_wr_addr,
   input  logic [DWIDTH-1:0] i_wr_data,
   input  logic [AWIDTH-1:0] i_rd_addr,
   output logic [DWIDTH-1:0] o_rd_data
);

   logic [DWIDTH-1:0] r_mem [fifo_depth(AWIDTH)];

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/i2c_fifo.sv
// First-word-fall-through FIFO between the APB register block and module_i2c.
// Flags are decoded from registered pointers only, so no request input reaches an output.
module i2c_fifo
   import i2c_fifo_pkg::*;
#(
   parameter int DWIDTH    = I2C_FIFO_DWIDTH,
   parameter int AWIDTH    = I2C_FIFO_AWIDTH,
   parameter int AFULL_LVL = 12
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              flush,
   input  logic              err_clr,
   input  logic              wr_en,
   input  logic [DWIDTH-1:0] data_in,
   input  logic              rd_en,
   output logic [DWIDTH-1:0] data_out,
   output logic              f_full,
   output logic              f_empty,
   output logic              f_afull,
   output logic [AWIDTH:0]   count,
   output logic              err_overflow,
   output logic              err_underflow
);

   localparam logic [AWIDTH:0] LP_ONE   = {{AWIDTH{1'b0}}, 1'b1};
   localparam logic [AWIDTH:0] LP_AFULL = (AWIDTH+1)'(AFULL_LVL);

   logic [AWIDTH:0]   r_wr_ptr;
   logic [AWIDTH:0]   r_rd_ptr;
   logic              r_err_ovf;
   logic              r_err_udf;

   logic [AWIDTH:0]   w_count;
   logic              w_empty;
   logic              w_full;
   logic              w_push;
   logic              w_pop;
   logic              w_ovf_set;
   logic              w_udf_set;
   logic              w_mem_we;
   logic [DWIDTH-1:0] w_rd_data;
   fifo_status_t      w_status;

   // Wrap bit distinguishes full from empty when the index bits coincide.
   assign w_count = r_wr_ptr - r_rd_ptr;
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AWIDTH] != r_rd_ptr[AWIDTH]) &&
                    (r_wr_ptr[AWIDTH-1:0] == r_rd_ptr[AWIDTH-1:0]);

   // A pop frees the slot a full-FIFO push lands in; flush swallows both requests.
   assign w_push    = wr_en && (!w_full || rd_en) && !flush;
   assign w_pop     = rd_en && !w_empty && !flush;
   assign w_ovf_set = wr_en && w_full && !rd_en && !flush;
   assign w_udf_set = rd_en && w_empty && !flush;
   assign w_mem_we  = w_push && !PRESET;

   always_ff @(posedge PCLK) begin
      if (PRESET || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + LP_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + LP_ONE;
         end
      end
   end

   // Sticky errors survive flush; a new error wins over a same-cycle clear.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_err_ovf <= 1'b0;
         r_err_udf <= 1'b0;
      end else begin
         if (w_ovf_set) begin
            r_err_ovf <= 1'b1;
         end else if (err_clr) begin
            r_err_ovf <= 1'b0;
         end
         if (w_udf_set) begin
            r_err_udf <= 1'b1;
         end else if (err_clr) begin
            r_err_udf <= 1'b0;
         end
      end
   end

   i2c_fifo_mem #(
      .DWIDTH (DWIDTH),
      .AWIDTH (AWIDTH)
   ) u_mem (
      .i_clk     (PCLK),
      .i_wr_en   (w_mem_we),
      .i_wr_addr (r_wr_ptr[AWIDTH-1:0]),
      .i_wr_data (data_in),
      .i_rd_addr (r_rd_ptr[AWIDTH-1:0]),
      .o_rd_data (w_rd_data)
   );

   always_comb begin
      w_status               = '0;
      w_status.f_full        = w_full;
      w_status.f_empty       = w_empty;
      w_status.f_afull       = (w_count >= LP_AFULL);
      w_status.err_overflow  = r_err_ovf;
      w_status.err_underflow = r_err_udf;
   end

   assign data_out      = w_empty ? '0 : w_rd_data;
   assign count         = w_count;
   assign f_full        = w_status.f_full;
   assign f_empty       = w_status.f_empty;
   assign f_afull       = w_status.f_afull;
   assign err_overflow  = w_status.err_overflow;
   assign err_underflow = w_status.err_underflow;

endmodule

// File: tb/tb_i2c_fifo.sv
// Directed bench for i2c_fifo at default geometry (32-bit words, 16 entries, afull at 12).
`timescale 1ns/1ps
module tb_i2c_fifo;

   logic        PCLK = 1'b0;
   logic        PRESET = 1'b0;
   logic        flush = 1'b0;
   logic        err_clr = 1'b0;
   logic        wr_en = 1'b0;
   logic [31:0] data_in = '0;
   logic        rd_en = 1'b0;
   logic [31:0] data_out;
   logic        f_full;
   logic        f_empty;
   logic        f_afull;
   logic [4:0]  count;
   logic        err_overflow;
   logic        err_underflow;

   int n_cmp = 0;
   int n_bad = 0;

   i2c_fifo #(
      .DWIDTH    (32),
      .AWIDTH    (4),
      .AFULL_LVL (12)
   ) dut (
      .PCLK          (PCLK),
      .PRESET        (PRESET),
      .flush         (flush),
      .err_clr       (err_clr),
      .wr_en         (wr_en),
      .data_in       (data_in),
      .rd_en         (rd_en),
      .data_out      (data_out),
      .f_full        (f_full),
      .f_empty       (f_empty),
      .f_afull       (f_afull),
      .count         (count),
      .err_overflow  (err_overflow),
      .err_underflow (err_underflow)
   );

   always #5 PCLK = ~PCLK;

   // Inputs change and outputs are sampled 1 ns after the rising edge.
   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic push(input logic [31:0] d);
      wr_en = 1'b1; data_in = d; rd_en = 1'b0;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic pop();
      rd_en = 1'b1; wr_en = 1'b0;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      PRESET = 1'b1;
      tick();
      tick();
      PRESET = 1'b0;
      n_cmp++; if (f_empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got %b want 1", f_empty); end
      n_cmp++; if (f_full !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b want 0", f_full); end
      n_cmp++; if (f_afull !== 1'b0) begin n_bad++; $display("FAIL reset_afull got %b want 0", f_afull); end
      n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
      n_cmp++; if (data_out !== 32'h0) begin n_bad++; $display("FAIL reset_dout got %h want 0", data_out); end
      n_cmp++; if ({err_overflow, err_underflow} !== 2'b00) begin n_bad++; $display("FAIL reset_err got %b%b want 00", err_overflow, err_underflow); end
   endtask

   task automatic test_fill_drain();
      for (int i = 1; i <= 16; i++) begin
         push(32'(i));
         n_cmp++; if (count !== 5'(i)) begin n_bad++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i); end
         n_cmp++; if (data_out !== 32'h1) begin n_bad++; $display("FAIL fill_head[%0d] got %h want 1", i, data_out); end
         n_cmp++; if (f_afull !== (i >= 12)) begin n_bad++; $display("FAIL fill_afull[%0d] got %b want %b", i, f_afull, (i >= 12)); end
         n_cmp++; if (f_full !== (i == 16)) begin n_bad++; $display("FAIL fill_full[%0d] got %b want %b", i, f_full, (i == 16)); end
      end
      for (int i = 1; i <= 16; i++) begin
         n_cmp++; if (data_out !== 32'(i)) begin n_bad++; $display("FAIL drain_order[%0d] got %h want %h", i, data_out, 32'(i)); end
         pop();
         n_cmp++; if (count !== 5'(16 - i)) begin n_bad++; $display("FAIL drain_count[%0d] got %0d want %0d", i, count, 16 - i); end
      end
      n_cmp++; if (f_empty !== 1'b1) begin n_bad++; $display("FAIL drain_empty got %b want 1", f_empty); end
      n_cmp++; if (data_out !== 32'h0) begin n_bad++; $display("FAIL drain_dout got %h want 0", data_out); end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 10; i++) push(32'h100 + 32'(i));
      for (int i = 0; i < 10; i++) begin
         n_cmp++; if (data_out !== 32'h100 + 32'(i)) begin n_bad++; $display("FAIL wrap_a[%0d] got %h want %h", i, data_out, 32'h100 + 32'(i)); end
         pop();
      end
      for (int i = 0; i < 16; i++) push(32'h200 + 32'(i));
      n_cmp++; if (f_full !== 1'b1) begin n_bad++; $display("FAIL wrap_full got %b want 1", f_full); end
      for (int i = 0; i < 16; i++) begin
         n_cmp++; if (data_out !== 32'h200 + 32'(i)) begin n_bad++; $display("FAIL wrap_b[%0d] got %h want %h", i, data_out, 32'h200 + 32'(i)); end
         pop();
      end
      n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL wrap_count got %0d want 0", count); end
   endtask

   task automatic test_full_rw();
      for (int i = 0; i < 16; i++) push(32'h300 + 32'(i));
      wr_en = 1'b1; rd_en = 1'b1; data_in = 32'hDEADBEEF;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL fullrw_count got %0d want 16", count); end
      n_cmp++; if (f_full !== 1'b1) begin n_bad++; $display("FAIL fullrw_full got %b want 1", f_full); end
      n_cmp++; if (data_out !== 32'h301) begin n_bad++; $display("FAIL fullrw_head got %h want 301", data_out); end
      n_cmp++; if (err_overflow !== 1'b0) begin n_bad++; $display("FAIL fullrw_ovf got %b want 0", err_overflow); end
      for (int i = 1; i <= 15; i++) begin
         n_cmp++; if (data_out !== 32'h300 + 32'(i)) begin n_bad++; $display("FAIL fullrw_order[%0d] got %h want %h", i, data_out, 32'h300 + 32'(i)); end
         pop();
      end
      n_cmp++; if (data_out !== 32'hDEADBEEF) begin n_bad++; $display("FAIL fullrw_tail got %h want deadbeef", data_out); end
      n_cmp++; if (count !== 5'd1) begin n_bad++; $display("FAIL fullrw_tail_count got %0d want 1", count); end
      pop();
      n_cmp++; if (f_empty !== 1'b1) begin n_bad++; $display("FAIL fullrw_empty got %b want 1", f_empty); end
   endtask

   task automatic test_errors();
      pop();
      n_cmp++; if (err_underflow !== 1'b1) begin n_bad++; $display("FAIL err_udf got %b want 1", err_underflow); end
      n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL err_udf_count got %0d want 0", count); end
      for (int i = 0; i < 16; i++) push(32'h400 + 32'(i));
      push(32'h00000BAD);
      n_cmp++; if (err_overflow !== 1'b1) begin n_bad++; $display("FAIL err_ovf got %b want 1", err_overflow); end
      n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL err_ovf_count got %0d want 16", count); end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      n_cmp++; if ({err_overflow, err_underflow} !== 2'b00) begin n_bad++; $display("FAIL err_clr got %b%b want 00", err_overflow, err_underflow); end
      err_clr = 1'b1; wr_en = 1'b1; data_in = 32'h00000BAD;
      tick();
      err_clr = 1'b0; wr_en = 1'b0;
      n_cmp++; if (err_overflow !== 1'b1) begin n_bad++; $display("FAIL err_set_wins got %b want 1", err_overflow); end
      for (int i = 0; i < 16; i++) begin
         n_cmp++; if (data_out !== 32'h400 + 32'(i)) begin n_bad++; $display("FAIL err_drop[%0d] got %h want %h", i, data_out, 32'h400 + 32'(i)); end
         pop();
      end
      n_cmp++; if (f_empty !== 1'b1) begin n_bad++; $display("FAIL err_drop_empty got %b want 1", f_empty); end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      wr_en = 1'b1; rd_en = 1'b1; data_in = 32'h55;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      n_cmp++; if (count !== 5'd1) begin n_bad++; $display("FAIL empty_rw_count got %0d want 1", count); end
      n_cmp++; if (data_out !== 32'h55) begin n_bad++; $display("FAIL empty_rw_dout got %h want 55", data_out); end
      n_cmp++; if (err_underflow !== 1'b1) begin n_bad++; $display("FAIL empty_rw_udf got %b want 1", err_underflow); end
      pop();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
   endtask

   task automatic test_flush();
      for (int i = 0; i < 16; i++) push(32'h500 + 32'(i));
      push(32'h00000BAD);
      for (int i = 0; i < 11; i++) pop();
      n_cmp++; if (count !== 5'd5) begin n_bad++; $display("FAIL flush_pre_count got %0d want 5", count); end
      n_cmp++; if (err_overflow !== 1'b1) begin n_bad++; $display("FAIL flush_pre_ovf got %b want 1", err_overflow); end
      flush = 1'b1; wr_en = 1'b1; data_in = 32'h0000F00D;
      tick();
      flush = 1'b0; wr_en = 1'b0;
      n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL flush_count got %0d want 0", count); end
      n_cmp++; if (f_empty !== 1'b1) begin n_bad++; $display("FAIL flush_empty got %b want 1", f_empty); end
      n_cmp++; if (err_overflow !== 1'b1) begin n_bad++; $display("FAIL flush_ovf got %b want 1", err_overflow); end
      n_cmp++; if (data_out !== 32'h0) begin n_bad++; $display("FAIL flush_dout got %h want 0", data_out); end
      push(32'h77);
      n_cmp++; if (data_out !== 32'h77) begin n_bad++; $display("FAIL flush_next got %h want 77", data_out); end
      n_cmp++; if (count !== 5'd1) begin n_bad++; $display("FAIL flush_next_count got %0d want 1", count); end
      PRESET = 1'b1;
      tick();
      PRESET = 1'b0;
      n_cmp++; if ({err_overflow, count} !== 6'd0) begin n_bad++; $display("FAIL final_reset got ovf=%b cnt=%0d want 0/0", err_overflow, count); end
   endtask

   initial begin
      #1;
      test_reset();
      test_fill_drain();
      test_wrap();
      test_full_rw();
      test_errors();
      test_flush();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/i2c_fifo.md
Name: i2c_fifo

Overview:
- Synchronous first-word-fall-through FIFO that buffers words between the APB register interface and module_i2c.
- Two instances are used:
  - TX instance: written by the APB slave, drained by module_i2c through fifo_tx_rd_en.
  - RX instance: filled by module_i2c through fifo_rx_wr_en, drained by APB reads.
- Provides the full/empty flags that module_i2c consumes (fifo_tx_f_full/empty, fifo_rx_f_full/empty), plus occupancy and sticky error flags for status registers.

Parameters:
- DWIDTH, 32, data word width; matches module_i2c DWIDTH.
- AWIDTH, 4, pointer width; depth = 2**AWIDTH entries (16 by default).
- AFULL_LVL, 12, occupancy at or above which f_afull asserts; legal range 1..2**AWIDTH.

Ports:
- PCLK  input  1  clock; all state updates on its rising edge.
- PRESET  input  1  synchronous active-high reset, sampled on the rising edge of PCLK.
- flush  input  1  synchronous clear of contents; same effect as reset except on the err_* flags.
- err_clr  input  1  clears the sticky overflow/underflow flags.
- wr_en  input  1  push request.
- data_in  input  DWIDTH  push data.
- rd_en  input  1  pop request.
- data_out  output  DWIDTH  head entry (FWFT).
- f_full  output  1  occupancy == 2**AWIDTH.
- f_empty  output  1  occupancy == 0.
- f_afull  output  1  occupancy >= AFULL_LVL.
- count  output  AWIDTH+1  current occupancy, 0..2**AWIDTH.
- err_overflow  output  1  sticky; set by a rejected push.
- err_underflow  output  1  sticky; set by a rejected pop.

Behaviour:
- Reset (PRESET=1 at a PCLK edge) has priority over everything:
  - wr_ptr=0, rd_ptr=0, count=0.
  - f_empty=1, f_full=0, f_afull=0.
  - err_overflow=0, err_underflow=0.
  - data_out=0. Memory contents are not cleared, but data_out is forced to 0 while empty.
- Flush (PRESET=0, flush=1):
  - Pointers and count go to 0; f_empty=1.
  - Any wr_en/rd_en in the same cycle is ignored.
  - err_* flags are unchanged.
- Pointers are AWIDTH+1 bits with an extra wrap bit:
  - empty when the pointers are fully equal.
  - full when the MSBs differ and the lower bits are equal.
  - count = wr_ptr - rd_ptr, computed modulo 2**(AWIDTH+1).
- Push accepted when wr_en && (!f_full || rd_en): mem[wr_ptr[AWIDTH-1:0]] <= data_in, wr_ptr increments and wraps naturally.
- Pop accepted when rd_en && !f_empty: rd_ptr increments.
- data_out = mem[rd_ptr[AWIDTH-1:0]] when !f_empty, else 0.
  - A word pushed at edge N is visible on data_out after edge N if the FIFO was empty: zero-cycle fall-through latency from the write edge.
- Simultaneous push and pop:
  - Not empty (including full): both are accepted, count unchanged, flags unchanged.
  - Empty: the push is accepted, the pop is rejected and err_underflow sets; count becomes 1.
- Rejected push (wr_en, full, no rd_en):
  - Data is dropped; pointers unchanged.
  - err_overflow <= 1 on the next edge.
- Rejected pop (rd_en while empty): pointers unchanged; err_underflow <= 1.
- Sticky flags:
  - Held until err_clr or reset.
  - If err_clr and a new error occur in the same cycle, the flag is set (the set wins).
- All flags (f_full, f_empty, f_afull, count) are registered or derived purely from registered pointers. They are glitch-free and update on the same edge as the pointers.
- There is no combinational path from wr_en/rd_en to any output.

Decomposition:
- Package i2c_fifo_pkg holds:
  - the DWIDTH/AWIDTH defaults, shared with module_i2c;
  - a localparam function for depth;
  - a typedef for the status bundle {f_full, f_empty, f_afull, err_overflow, err_underflow}, reused by the APB status register.
- One natural sub-module: i2c_fifo_mem, a simple dual-port register array with synchronous write and asynchronous read.
- Pointer, flag and error logic stays in i2c_fifo.

Test Plan:
- Reset: drive PRESET=1 for 2 cycles, then release -> f_empty=1, f_full=0, count=0, data_out=0, err_*=0.
- Fill/drain: push 0x00000001..0x00000010 (16 words, default depth).
  - After the 12th push, f_afull=1; after the 16th, f_full=1 and count=16.
  - Pop 16 times: data_out order is 1..16; f_empty=1 after the last pop.
- Wrap-around: push 10, pop 10, push 16, pop 16 -> data order preserved across the pointer wrap; count returns to 0.
- Full with simultaneous push/pop:
  - With the FIFO full, assert wr_en=rd_en=1 with data_in=0xDEADBEEF -> count stays 16, head advances, err_overflow stays 0.
  - 0xDEADBEEF appears at data_out after 15 further pops.
- Errors:
  - Push while full (rd_en=0) -> err_overflow=1 and the word is dropped.
  - Pop while empty -> err_underflow=1.
  - err_clr for 1 cycle -> both flags 0.
  - err_clr together with a new overflow -> err_overflow stays 1.
- Flush mid-operation: with count=5 and err_overflow=1, assert flush together with wr_en -> next cycle count=0, f_empty=1, err_overflow=1, and the pushed word is discarded.
